// File: rtl/snax_tcdm_responder.sv
// Banked, word-interleaved TCDM target: per-bank round-robin arbitration over requester ports,
// byte-strobed SRAM banks and a fixed-latency per-port response pipeline.
package snax_tcdm_pkg;
  localparam int TcdmAddrWidth = 17;
  localparam int TcdmDataWidth = 64;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0]   addr;
    logic                       write;
    logic [3:0]                 amo;
    logic [TcdmDataWidth-1:0]   data;
    logic [TcdmDataWidth/8-1:0] strb;
    logic                       user;
  } tcdm_req_chan_t;

  typedef struct packed {
    logic           q_valid;
    tcdm_req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;
endpackage

module snax_tcdm_bank #(
  parameter int NumPorts  = 24,
  parameter int BankDepth = 512,
  parameter int DataWidth = 64,
  parameter int RowWidth  = $clog2(BankDepth),
  parameter int StrbWidth = DataWidth / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  hit,
  input  logic [NumPorts-1:0]                  write,
  input  logic [NumPorts-1:0][RowWidth-1:0]    row,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata,
  input  logic [NumPorts-1:0][StrbWidth-1:0]   strb,
  output logic [NumPorts-1:0]                  gnt,
  output logic [DataWidth-1:0]                 rdata
);
  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [DataWidth-1:0] mem [BankDepth];
  logic [PW-1:0]        rr_ptr, sel;
  logic                 found;

  // Two passes give the wrapping search: ports >= rr_ptr first, then the rest from 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    gnt   = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!found && hit[p] && (PW'(p) >= rr_ptr)) begin
        found  = 1'b1;
        sel    = PW'(p);
        gnt[p] = 1'b1;
      end
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (!found && hit[p]) begin
        found  = 1'b1;
        sel    = PW'(p);
        gnt[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr <= '0;
    else if (found) rr_ptr <= (sel == PW'(NumPorts - 1)) ? '0 : sel + 1'b1;
  end

  // hit is already masked by reset, so no write can land while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (found && write[sel]) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (strb[sel][b]) mem[row[sel]][8*b +: 8] <= wdata[sel][8*b +: 8];
      end
    end
  end

  assign rdata = mem[row[sel]];
endmodule

module snax_tcdm_responder
  import snax_tcdm_pkg::*;
#(
  parameter int NumPorts   = 24,
  parameter int NumBanks   = 32,
  parameter int BankDepth  = 512,
  parameter int DataWidth  = TcdmDataWidth,
  parameter int AddrWidth  = TcdmAddrWidth,
  parameter int RspLatency = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  tcdm_req_t tcdm_req_i [NumPorts],
  output tcdm_rsp_t tcdm_rsp_o [NumPorts]
);
  localparam int WOff = $clog2(DataWidth / 8);
  localparam int BW   = $clog2(NumBanks);
  localparam int RW   = $clog2(BankDepth);
  localparam int SW   = DataWidth / 8;

  logic [NumPorts-1:0]                 q_valid, write, gnt, unused_req;
  logic [NumPorts-1:0][BW-1:0]         bank_of;
  logic [NumPorts-1:0][RW-1:0]         row;
  logic [NumPorts-1:0][DataWidth-1:0]  wdata;
  logic [NumPorts-1:0][SW-1:0]         strb;
  logic [NumBanks-1:0][NumPorts-1:0]   bank_gnt;
  logic [NumBanks-1:0][DataWidth-1:0]  bank_rdata;

  for (genvar p = 0; p < NumPorts; p++) begin : g_dec
    logic [AddrWidth-1:0] addr;
    assign addr          = tcdm_req_i[p].q.addr;
    assign q_valid[p]    = tcdm_req_i[p].q_valid;
    assign write[p]      = tcdm_req_i[p].q.write;
    assign wdata[p]      = tcdm_req_i[p].q.data;
    assign strb[p]       = tcdm_req_i[p].q.strb;
    assign bank_of[p]    = addr[WOff +: BW];
    assign row[p]        = addr[WOff+BW +: RW];
    // amo/user and the out-of-range address bits have no effect on behaviour.
    assign unused_req[p] = ^{tcdm_req_i[p].q.amo, tcdm_req_i[p].q.user, addr};
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [NumPorts-1:0] hit;
    always_comb begin
      hit = '0;
      for (int p = 0; p < NumPorts; p++)
        hit[p] = q_valid[p] && !rst_i && (bank_of[p] == BW'(b));
    end

    snax_tcdm_bank #(
      .NumPorts (NumPorts),
      .BankDepth(BankDepth),
      .DataWidth(DataWidth)
    ) u_bank (
      .clk_i,
      .rst_i,
      .hit,
      .write,
      .row,
      .wdata,
      .strb,
      .gnt  (bank_gnt[b]),
      .rdata(bank_rdata[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < NumBanks; b++) gnt |= bank_gnt[b];
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_rsp
    logic                                 vld_in;
    logic [DataWidth-1:0]                 dat_in;
    logic [RspLatency:1]                  vld_pipe;
    logic [RspLatency:1][DataWidth-1:0]   dat_pipe;

    // Write responses carry zero data, so no separate is_read flag is needed downstream.
    assign vld_in = gnt[p];
    assign dat_in = (gnt[p] && !write[p]) ? bank_rdata[bank_of[p]] : '0;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        for (int s = RspLatency; s > 1; s--) begin
          vld_pipe[s] <= vld_pipe[s-1];
          dat_pipe[s] <= dat_pipe[s-1];
        end
        vld_pipe[1] <= vld_in;
        dat_pipe[1] <= dat_in;
      end
    end

    assign tcdm_rsp_o[p] = '{
      q_ready: gnt[p],
      p_valid: vld_pipe[RspLatency] & ~rst_i,
      p:       '{data: dat_pipe[RspLatency] & {DataWidth{~rst_i}}}
    };
  end
endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Scoreboarded bench: the same request stream drives a latency-1 and a latency-3 responder;
// expected responses are queued at grant time and matched by an independent monitor.
module tb_snax_tcdm_responder;
  import snax_tcdm_pkg::*;

  localparam int NP = 24;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  tcdm_req_t req  [NP];
  tcdm_rsp_t rsp1 [NP];
  tcdm_rsp_t rsp3 [NP];

  always #5 clk = ~clk;

  snax_tcdm_responder #(.RspLatency(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_rsp_o(rsp1));
  snax_tcdm_responder #(.RspLatency(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_rsp_o(rsp3));

  typedef struct {
    int          d;
    int          p;
    int          cyc;
    logic [63:0] data;
  } exp_t;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] exp_d [NP];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endfunction

  function automatic logic [NP-1:0] qready(int d);
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (d == 1) ? rsp3[p].q_ready : rsp1[p].q_ready;
    return r;
  endfunction

  task automatic clr();
    for (int p = 0; p < NP; p++) req[p] = '0;
  endtask

  task automatic rd(int p, logic [16:0] a, logic [63:0] e);
    req[p]         = '0;
    req[p].q_valid = 1'b1;
    req[p].q.addr  = a;
    req[p].q.amo   = 4'(p);
    req[p].q.user  = p[0];
    req[p].q.strb  = 8'hA5;
    exp_d[p]       = e;
  endtask

  task automatic wr(int p, logic [16:0] a, logic [63:0] dat, logic [7:0] s);
    req[p]         = '0;
    req[p].q_valid = 1'b1;
    req[p].q.addr  = a;
    req[p].q.write = 1'b1;
    req[p].q.data  = dat;
    req[p].q.strb  = s;
    exp_d[p]       = '0;
  endtask

  // Checks the grant vector of both DUTs this cycle and queues the expected responses.
  task automatic gnt_chk(string name, logic [NP-1:0] m, bit push);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s q_ready d%0d", name, d), 64'(qready(d)), 64'(m));
      if (push)
        for (int p = 0; p < NP; p++)
          if (m[p]) sb.push_back('{d: d, p: p, cyc: cyc + ((d == 1) ? 3 : 1), data: exp_d[p]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic        mon_pv, mon_idle_bad;
  logic [63:0] mon_pd;
  int          mon_k;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_idle_bad = 1'b0;
      for (int p = 0; p < NP; p++) begin
        mon_pv = (d == 1) ? rsp3[p].p_valid : rsp1[p].p_valid;
        mon_pd = (d == 1) ? rsp3[p].p.data  : rsp1[p].p.data;
        if (mon_pv) begin
          mon_k = -1;
          for (int i = 0; i < sb.size(); i++)
            if (mon_k < 0 && sb[i].d == d && sb[i].p == p && sb[i].cyc == cyc) mon_k = i;
          if (mon_k < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp d%0d p%0d cyc %0d: got p_valid=1 data %h expected p_valid=0",
                     d, p, cyc, mon_pd);
          end else begin
            check($sformatf("rsp data d%0d p%0d cyc %0d", d, p, cyc), mon_pd, sb[mon_k].data);
            sb.delete(mon_k);
          end
        end else if (mon_pd != '0) begin
          mon_idle_bad = 1'b1;
        end
      end
      check($sformatf("idle data zero d%0d cyc %0d", d, cyc), 64'(mon_idle_bad), 64'd0);
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp d%0d p%0d cyc %0d: got p_valid=0 expected p_valid=1 data %h",
                 sb[i].d, sb[i].p, sb[i].cyc, sb[i].data);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst = 1'b1;

    // Reset held with every port requesting: nothing may be granted.
    for (int p = 0; p < NP; p++) wr(p, 17'(p * 8), 64'hC0DE_0000_0000_0000 + 64'(p), 8'hFF);
    repeat (3) begin
      @(negedge clk);
      check("reset q_ready d0", 64'(qready(0)), 64'd0);
      check("reset q_ready d1", 64'(qready(1)), 64'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    gnt_chk("release all", {NP{1'b1}}, 1'b1);
    clr();

    // Write then read-after-write from another port.
    wr(0, 17'h0, 64'hDEADBEEF_01234567, 8'hFF);
    gnt_chk("t2 wr", 24'h000001, 1'b1);
    clr();
    rd(5, 17'h0, 64'hDEADBEEF_01234567);
    gnt_chk("t2 rd", 24'h000020, 1'b1);
    clr();

    // Byte strobes: only the low four bytes change.
    wr(3, 17'h100, 64'h0, 8'hFF);
    gnt_chk("t3 clr", 24'h000008, 1'b1);
    clr();
    wr(3, 17'h100, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
    gnt_chk("t3 strb", 24'h000008, 1'b1);
    clr();
    rd(4, 17'h100, 64'h00000000_FFFFFFFF);
    gnt_chk("t3 rd", 24'h000010, 1'b1);
    clr();

    // Bank-0 conflict: rr_ptr is 8 after port 7, so grants go 0, 1, 2.
    wr(7, 17'h200, 64'h01234567_89ABCDEF, 8'hFF);
    gnt_chk("t4 wr", 24'h000080, 1'b1);
    clr();
    rd(0, 17'h000, 64'hDEADBEEF_01234567);
    rd(1, 17'h100, 64'h00000000_FFFFFFFF);
    rd(2, 17'h200, 64'h01234567_89ABCDEF);
    gnt_chk("t4 c0", 24'h000001, 1'b1);
    req[0].q_valid = 1'b0;
    gnt_chk("t4 c1", 24'h000002, 1'b1);
    req[1].q_valid = 1'b0;
    gnt_chk("t4 c2", 24'h000004, 1'b1);
    clr();

    // Sixteen ports on sixteen distinct banks all complete in one cycle.
    for (int p = 8; p < 16; p++) wr(p, 17'(32'h1000 + p * 8), 64'hF00D_0000_0000_0000 + 64'(p), 8'hFF);
    gnt_chk("t5 wr", 24'h00FF00, 1'b1);
    clr();
    for (int p = 0; p < 8; p++)
      rd(p, 17'(p * 8), (p == 0) ? 64'hDEADBEEF_01234567 : 64'hC0DE_0000_0000_0000 + 64'(p));
    for (int p = 8; p < 16; p++) rd(p, 17'(32'h1000 + p * 8), 64'hF00D_0000_0000_0000 + 64'(p));
    gnt_chk("t5 rd", 24'h00FFFF, 1'b1);
    clr();
    idle(5);

    // Granted reads are dropped by a reset pulse the following cycle.
    for (int p = 16; p < 24; p++) rd(p, 17'(p * 8), 64'hC0DE_0000_0000_0000 + 64'(p));
    gnt_chk("t6 gnt", 24'hFF0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t6 rst q_ready d0", 64'(qready(0)), 64'd0);
    check("t6 rst q_ready d1", 64'(qready(1)), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    idle(6);
    for (int p = 16; p < 24; p++) rd(p, 17'(p * 8), 64'hC0DE_0000_0000_0000 + 64'(p));
    gnt_chk("t6 reread", 24'hFF0000, 1'b1);
    clr();
    idle(6);

    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
